// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_pkg : shared types and constants for the serial CNN grid solver      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BU    = 3'd2,
    S_ITER  = 3'd3,
    S_CHECK = 3'd4,
    S_OUT   = 3'd5
  } cnn_state_e;

  // 3x3 neighbour offsets in raster order; k=4 is the centre cell
  localparam int NB_DR [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int NB_DC [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  function automatic int q_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int q_one_x(input int frac);
    return 1 << (2 * frac);
  endfunction

  localparam int FRAC_DEFAULT = 4;
  localparam int ONE          = q_one(FRAC_DEFAULT);
  localparam int ONE_X        = q_one_x(FRAC_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/cnn_cell_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_cell_update : saturating forward-Euler state step and output clamp   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cnn_cell_update
  import cnn_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int FRAC       = 4,
  parameter int STEP_SHIFT = 2,
  parameter int ACC_W      = 2 * WIDTH + 5
) (
  input  logic signed [2*WIDTH-1:0] x,
  input  logic signed [ACC_W-1:0]   acc,
  output logic signed [2*WIDTH-1:0] x_new,
  output logic signed [2*WIDTH-1:0] y_new
);

  localparam int c_xw = 2 * WIDTH;
  localparam int c_sw = ACC_W + 2;
  localparam logic signed [c_sw-1:0] c_xmax = {{(c_sw-c_xw+1){1'b0}}, {(c_xw-1){1'b1}}};
  localparam logic signed [c_sw-1:0] c_xmin = {{(c_sw-c_xw+1){1'b1}}, {(c_xw-1){1'b0}}};
  localparam logic signed [c_xw-1:0] c_pos1 = c_xw'(q_one_x(FRAC));
  localparam logic signed [c_xw-1:0] c_neg1 = c_xw'(-q_one_x(FRAC));

  logic signed [c_sw-1:0] w_diff;
  logic signed [c_sw-1:0] w_sum;

  always_comb begin
    w_diff = c_sw'(acc) - c_sw'(x);
    w_sum  = c_sw'(x) + (w_diff >>> STEP_SHIFT);
    if (w_sum > c_xmax) begin
      x_new = c_xmax[c_xw-1:0];
    end else if (w_sum < c_xmin) begin
      x_new = c_xmin[c_xw-1:0];
    end else begin
      x_new = w_sum[c_xw-1:0];
    end
    if (x_new > c_pos1) begin
      y_new = c_pos1;
    end else if (x_new < c_neg1) begin
      y_new = c_neg1;
    end else begin
      y_new = x_new;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_grid_solver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_grid_solver : time-multiplexed CNN solver, one cell per clock        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cnn_grid_solver
  import cnn_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int FRAC       = FRAC_DEFAULT,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int STEP_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9*WIDTH-1:0]        a_tmpl,
  input  logic [9*WIDTH-1:0]        b_tmpl,
  input  logic signed [WIDTH-1:0]   i_bias,
  input  logic [7:0]                max_iter,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_u,
  input  logic signed [2*WIDTH-1:0] in_x0,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out_y,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                iter_count,
  output logic                      converged
);

  localparam int c_n  = ROWS * COLS;
  localparam int c_iw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_rw = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_cw = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_xw = 2 * WIDTH;
  localparam int c_aw = 2 * WIDTH + 5;
  localparam int c_pw = 3 * WIDTH;
  localparam logic signed [c_xw-1:0] c_pos1 = c_xw'(q_one_x(FRAC));
  localparam logic signed [c_xw-1:0] c_neg1 = c_xw'(-q_one_x(FRAC));

  cnn_state_e r_state, w_state_next;

  logic [9*WIDTH-1:0]      r_a, r_b;
  logic signed [WIDTH-1:0] r_bias;
  logic [7:0]              r_max_iter, r_iter_count;
  logic                    r_converged, r_busy, r_bank, r_changed;
  logic [c_iw-1:0]         r_idx;
  logic [c_rw-1:0]         r_row;
  logic [c_cw-1:0]         r_col;
  logic signed [c_xw-1:0]  r_out_y;

  logic signed [WIDTH-1:0] r_u_mem  [c_n];
  logic signed [c_aw-1:0]  r_bu_mem [c_n];
  logic signed [c_xw-1:0]  r_x_mem  [2][c_n];
  logic signed [c_xw-1:0]  r_y_mem  [2][c_n];

  logic signed [c_aw-1:0]  w_term [9];
  logic signed [c_aw-1:0]  w_sum, w_bias_q, w_acc;
  logic signed [c_xw-1:0]  w_x_new, w_y_new, w_x0_y;
  logic                    w_in_fire, w_out_fire, w_last, w_step, w_load_out, w_out_bank;
  logic [c_iw-1:0]         w_out_addr;
  logic [7:0]              w_iter_next;

  // One multiply per neighbour: B*u during BU, (A*y)>>FRAC during ITER
  for (genvar k = 0; k < 9; k++) begin : g_nb
    int                      w_nr, w_nc;
    logic                    w_inside;
    logic [c_iw-1:0]         w_nidx;
    logic signed [WIDTH-1:0] w_coef;
    logic signed [c_xw-1:0]  w_opnd;
    logic signed [c_pw-1:0]  w_prod;

    always_comb begin
      w_nr     = int'(r_row) + NB_DR[k];
      w_nc     = int'(r_col) + NB_DC[k];
      w_inside = (w_nr >= 0) && (w_nr < ROWS) && (w_nc >= 0) && (w_nc < COLS);
      w_nidx   = w_inside ? c_iw'(w_nr * COLS + w_nc) : '0;
      if (r_state == S_BU) begin
        w_coef = r_b[k*WIDTH +: WIDTH];
        w_opnd = c_xw'(r_u_mem[w_nidx]);
      end else begin
        w_coef = r_a[k*WIDTH +: WIDTH];
        w_opnd = r_y_mem[r_bank][w_nidx];
      end
      if (!w_inside) begin
        w_opnd = '0;
      end
      w_prod = c_pw'(w_coef) * c_pw'(w_opnd);
    end

    assign w_term[k] = (r_state == S_BU) ? c_aw'(w_prod) : c_aw'(w_prod >>> FRAC);
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++) begin
      w_sum = w_sum + w_term[k];
    end
  end

  assign w_bias_q = c_aw'(r_bias) <<< FRAC;
  assign w_acc    = r_bu_mem[r_idx] + w_sum;

  cnn_cell_update #(
    .WIDTH      (WIDTH),
    .FRAC       (FRAC),
    .STEP_SHIFT (STEP_SHIFT),
    .ACC_W      (c_aw)
  ) u_cell_update (
    .x     (r_x_mem[r_bank][r_idx]),
    .acc   (w_acc),
    .x_new (w_x_new),
    .y_new (w_y_new)
  );

  always_comb begin
    w_x0_y = in_x0;
    if (in_x0 > c_pos1) begin
      w_x0_y = c_pos1;
    end else if (in_x0 < c_neg1) begin
      w_x0_y = c_neg1;
    end
  end

  assign w_in_fire   = (r_state == S_LOAD) && in_valid;
  assign w_out_fire  = (r_state == S_OUT) && out_ready;
  assign w_last      = (r_idx == c_iw'(c_n - 1));
  assign w_step      = w_in_fire || (r_state == S_BU) || (r_state == S_ITER) || w_out_fire;
  assign w_iter_next = r_iter_count + 8'd1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  if (w_in_fire && w_last) w_state_next = S_BU;
      S_BU:    if (w_last) w_state_next = (r_max_iter == 8'd0) ? S_OUT : S_ITER;
      S_ITER:  if (w_last) w_state_next = S_CHECK;
      S_CHECK: w_state_next = (!r_changed || (w_iter_next == r_max_iter)) ? S_OUT : S_ITER;
      S_OUT:   if (w_out_fire && w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The bank swap in CHECK lands on the same edge that loads the first output
  assign w_load_out = ((w_state_next == S_OUT) && (r_state != S_OUT)) || (w_out_fire && !w_last);
  assign w_out_addr = (r_state == S_OUT) ? (r_idx + c_iw'(1)) : '0;
  assign w_out_bank = (r_state == S_CHECK) ? ~r_bank : r_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_bias       <= '0;
      r_max_iter   <= '0;
      r_iter_count <= '0;
      r_converged  <= 1'b0;
      r_busy       <= 1'b0;
      r_bank       <= 1'b0;
      r_changed    <= 1'b0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_out_y      <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_a          <= a_tmpl;
        r_b          <= b_tmpl;
        r_bias       <= i_bias;
        r_max_iter   <= max_iter;
        r_iter_count <= '0;
        r_converged  <= 1'b0;
        r_busy       <= 1'b1;
        r_bank       <= 1'b0;
        r_changed    <= 1'b0;
        r_idx        <= '0;
        r_row        <= '0;
        r_col        <= '0;
      end
      if (w_step) begin
        if (w_last) begin
          r_idx <= '0;
          r_row <= '0;
          r_col <= '0;
        end else begin
          r_idx <= r_idx + c_iw'(1);
          if (r_col == c_cw'(COLS - 1)) begin
            r_col <= '0;
            r_row <= r_row + c_rw'(1);
          end else begin
            r_col <= r_col + c_cw'(1);
          end
        end
      end
      if ((r_state == S_ITER) && (w_y_new != r_y_mem[r_bank][r_idx])) begin
        r_changed <= 1'b1;
      end
      if (r_state == S_CHECK) begin
        r_changed    <= 1'b0;
        r_iter_count <= w_iter_next;
        r_bank       <= ~r_bank;
        if (!r_changed) begin
          r_converged <= 1'b1;
        end
      end
      if (w_load_out) begin
        r_out_y <= r_y_mem[w_out_bank][w_out_addr];
      end
      if (w_out_fire && w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Cell storage carries no reset; contents are rewritten by every solve
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_u_mem[r_idx]    <= in_u;
      r_x_mem[0][r_idx] <= in_x0;
      r_y_mem[0][r_idx] <= w_x0_y;
    end
    if (r_state == S_BU) begin
      r_bu_mem[r_idx] <= w_sum + w_bias_q;
    end
    if (r_state == S_ITER) begin
      r_x_mem[~r_bank][r_idx] <= w_x_new;
      r_y_mem[~r_bank][r_idx] <= w_y_new;
    end
  end

  assign in_ready   = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_OUT);
  assign out_y      = r_out_y;
  assign busy       = r_busy;
  assign done       = w_out_fire && w_last;
  assign iter_count = r_iter_count;
  assign converged  = r_converged;

endmodule
`default_nettype wire

// File: doc/cnn_grid_solver.md
# cnn_grid_solver

Parametrised, time-multiplexed cellular-neural-network solver for a ROWS×COLS grid with 3×3 feedback (A) and control (B) templates, a bias I and a per-cell initial state. It replaces the fixed 4×4 instantiation with a single serial datapath. Cell inputs and initial states stream in, the block runs forward-Euler iterations until the outputs stop changing or an iteration limit is reached, and the settled outputs stream out. It sits between the image/frame buffer and downstream thresholding logic.

## Interface
- WIDTH, 9: template/input word width, signed Q(WIDTH-FRAC).FRAC
- FRAC, 4: fractional bits of template/input words
- ROWS, 4: grid rows
- COLS, 4: grid columns
- STEP_SHIFT, 2: Euler step dt = 2^-STEP_SHIFT
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_tmpl  in  9*WIDTH  feedback template; element k at [k*WIDTH +: WIDTH], k in raster order, k=4 is the centre
- b_tmpl  in  9*WIDTH  control template, same packing
- i_bias  in  WIDTH  bias I
- max_iter  in  8  iteration limit
- start  in  1  begin a solve; honoured only in IDLE
- in_valid / in_ready  in/out  1  load handshake
- in_u  in  WIDTH  cell input u, raster order
- in_x0  in  2*WIDTH  cell initial state, 2*FRAC fractional bits
- out_valid / out_ready  out/in  1  result handshake
- out_y  out  2*WIDTH  cell output y, raster order, 2*FRAC fractional bits
- busy  out  1  high from start acceptance until the last output is accepted
- done  out  1  one-cycle pulse on acceptance of the last output
- iter_count  out  8  iterations executed in the last solve
- converged  out  1  last solve ended on stability rather than on the limit

## Operation
- States: IDLE, LOAD, BU, ITER, CHECK, OUT.
- IDLE:
  - start=1 latches a_tmpl, b_tmpl, i_bias and max_iter.
  - Clears iter_count and converged, sets busy, goes to LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready transfer writes u and x0 for the next raster cell.
  - After N=ROWS*COLS transfers, goes to BU.
- BU: N cycles, one cell per cycle; stores bu[c] = Σ B·u + (I<<FRAC). Neighbours outside the grid contribute u=0.
- ITER:
  - N cycles, one cell per cycle.
  - acc = bu[c] + Σ A·y_prev. Outside neighbours give y=0.
  - x_new = sat(x + ((acc − x) >>> STEP_SHIFT)). Write x_new and y_new into the alternate bank.
  - y = clamp(x, −1.0, +1.0).
  - Set a change flag if y_new ≠ y_prev for the cell.
- CHECK (1 cycle):
  - Increment iter_count and swap banks.
  - No change during the iteration: converged=1, go to OUT.
  - Otherwise, if iter_count = max_iter: go to OUT.
  - Otherwise: back to ITER.
- max_iter=0: BU goes directly to OUT, emitting clamp(x0); iter_count=0, converged=0.
- OUT:
  - out_valid=1 with out_y of the current raster cell. Advance only on out_ready.
  - On the N-th accepted cell: done pulses, busy drops, state returns to IDLE.
- Arithmetic:
  - Products are 2*WIDTH bits.
  - Accumulator is 2*WIDTH+5 bits; it cannot overflow.
  - sat clamps to the signed 2*WIDTH range.
  - Shifts are arithmetic (floor).
- start in any state other than IDLE is ignored. Templates are used only as latched.

## Timing
- Reset values: in_ready=0, out_valid=0, out_y=0, busy=0, done=0, iter_count=0, converged=0. State goes to IDLE.
- rst_n low mid-solve aborts immediately. Memory contents are don't-care afterwards.
- busy rises the cycle after start is sampled. in_ready rises in that same cycle.
- Per-iteration latency is N+1 cycles; a pipelined datapath adds fixed fill cycles.
- Zero-backpressure solve: N (LOAD) + N (BU) + k·(N+1) (ITER/CHECK) + N (OUT) cycles, plus pipeline fill.
- out_y and out_valid are registered and held stable while out_ready=0.

## Structure
- Package cnn_pkg holds:
  - the state enum;
  - the 3×3 neighbour offset constants;
  - the Q-format helper constants: ONE = 1<<FRAC and ONE_X = 1<<(2*FRAC).
- Sub-module cnn_cell_update: combinational saturating Euler step plus output clamp, given x, acc and STEP_SHIFT.
- Storage: u, bu, and two x/y banks, each N deep (inferred RAM or register file).

## Test plan
- Reset and idle:
  - Assert rst_n=0 mid-ITER, then release → every output 0, state IDLE.
  - A following start runs normally.
- Null templates:
  - A=B=0, I=0, x0=0, max_iter=5 → all out_y=0.
  - iter_count=1, converged=1.
- Bias step:
  - A=B=0, I=+1.0 (16), x0=0, max_iter=1 → every out_y=0.25 (64).
  - iter_count=1, converged=0.
- Zero-padded boundary:
  - B all +1.0 (16), A=0, I=0, u=0.25 (4) everywhere, max_iter=1.
  - Corner out_y=64, edge out_y=96, interior out_y=144.
- Self-feedback saturation:
  - A centre=+2.0 (32), others 0, B=0, I=0, max_iter=20.
  - x0=+0.25 at cell 0, 0 elsewhere.
  - Expected: cell 0 out_y=+1.0 (256), others 0, converged=1.
- Handshake:
  - Hold out_ready=0 for 3 cycles mid-stream → out_y stable, no cell dropped or duplicated.
  - start pulsed during ITER → ignored.
  - done is a single pulse on the last accepted cell.
